mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store front-end between the pipeline MEM stage and DataMemory (word-wide, comb read, posedge write).
//  Converts byte/halfword/word loads and stores into word accesses:
//  - Extracts and extends sub-word load data.
//  - Performs read-modify-write for sub-word stores.
//  - Flags misaligned and out-of-range accesses.
//  Sole master of DataMemory's we/address/write_data; consumes its read_data.
// PARAMETERS
//  ADDR_MSB   22  highest address bit decoded; word index = addr[ADDR_MSB:2]; any set bit above -> range fault
//  RAM_WORDS  51  valid words; word index >= RAM_WORDS -> range fault
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset_n    in   1   asynchronous, active-low reset
//  req_valid  in   1   MEM-stage request present
//  req_ready  out  1   unit can accept a request this cycle
//  req_write  in   1   1=store, 0=load
//  req_size   in   2   00 byte, 01 halfword, 10 word, 11 reserved (faults)
//  req_signed in   1   loads only: sign-extend sub-word data
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data; sub-word stores use low bits
//  rsp_valid  out  1   one-cycle pulse: load data or fault reported
//  rsp_rdata  out  32  extended load data; 0 on fault and on store
//  rsp_fault  out  1   with rsp_valid: misaligned/range/reserved-size access
//  mem_we     out  1   to DataMemory we
//  mem_addr   out  32  to DataMemory address; always word-aligned ({..,2'b00})
//  mem_wdata  out  32  to DataMemory write_data
//  mem_rdata  in   32  from DataMemory read_data (combinational)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; rsp_valid=0; rsp_rdata=0; rsp_fault=0; mem_we=0; capture regs=0.
//    Reset during RMW aborts the store: no write issued.
//  - Accept: a request is accepted when req_valid & req_ready. req_ready=1 only in IDLE.
//  - Little-endian lanes: byte lane = addr[1:0]; halfword lane = addr[1].
//  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
//  - Faulting request (any type): no mem_we at any time.
//    Next cycle: rsp_valid=1, rsp_fault=1, rsp_rdata=0.
//  - Load (IDLE): mem_addr = {addr[31:2],2'b00} same cycle; lane extracted from mem_rdata.
//    Zero- or sign-extended per req_signed; word loads ignore req_signed.
//    Registered: rsp_valid=1 and rsp_rdata next cycle (latency 1). Back-to-back loads at 1/cycle.
//  - Word store (IDLE): mem_we=1, mem_wdata=req_wdata in the accept cycle (comb); rsp_valid stays 0.
//    Throughput 1/cycle.
//  - Sub-word store: accepted in IDLE with mem_we=0.
//    Captures aligned addr, lane, size and data; state -> RMW.
//  - RMW (exactly 1 cycle): req_ready=0.
//    mem_addr = captured addr; mem_wdata = mem_rdata with the target lane(s) replaced; mem_we=1.
//    State -> IDLE. Store occupancy 2 cycles; no rsp_valid.
//  - rsp_valid is a single-cycle pulse; there is no backpressure on responses.
//  - mem_we is never asserted in the same cycle as a load lookup.
//  - Idle (req_valid=0): mem_we=0; mem_addr holds the last driven value (don't-care).
//  - States: IDLE, RMW. Transitions:
//      IDLE -> RMW on accepted non-faulting sub-word store
//      RMW  -> IDLE unconditionally
// STRUCTURE
//  - Package mem_access_pkg holds:
//      SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD localparams
//      state encoding IDLE=1'b0, RMW=1'b1
//      lane-mask helper function
//  - Sub-module byte_lane_merge (pure comb), shared by load and RMW paths:
//      extract(word, lane, size, signed)
//      merge(word, data, lane, size)
//  - Top holds FSM, capture registers, fault decode, response registers.
// TESTING
//  1. mem[1]=0x11223344; LDR addr 0x4 -> next cycle rsp_valid=1, rsp_rdata=0x11223344, rsp_fault=0.
//  2. mem[2]=0x80FF7F01; LDRB signed at 0xA -> 0xFFFFFFFF; unsigned at 0xB -> 0x00000080;
//     LDRH signed at 0x8 -> 0x00007F01.
//  3. mem[3]=0xAABBCCDD; STRB 0x5A at 0xD -> req_ready low 1 cycle, mem_we in RMW only,
//     mem[3]=0xAABB5ADD; STRH 0x1234 at 0xE -> mem[3]=0x12345ADD.
//  4. LDR at 0x6, STRH at 0x3, size=11 -> no mem_we, each gives rsp_valid=1, rsp_fault=1, rsp_rdata=0;
//     addr 0x400 (word 256 >= 51) -> range fault.
//  5. STRB accepted, reset_n pulled low during RMW -> mem unchanged, outputs 0,
//     req_ready=1 after release.
//  6. STR 0x1 @0x0, LDR @0x0, STRB 0xFF @0x1, LDR @0x0 back-to-back with req_valid held ->
//     rsp 0x00000001 then 0x0000FF01; second load accepted only after RMW.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front-end: access sizes, FSM
// states and the byte-lane mask helpers used by the load and RMW paths.
package mem_access_pkg;

    localparam int ADDR_MSB_DEFAULT  = 22;
    localparam int RAM_WORDS_DEFAULT = 51;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

    // Byte-enable pattern of the lanes touched by an access of this size.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << lane;
            SIZE_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            expand_mask[8*i +: 8] = {8{be[i]}};
        end
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the MEM-stage request/response and DataMemory port signals.
// The unit itself connects through the slave modport.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Combinational lane logic: extracts/extends a sub-word from a memory word
// for loads, and splices store data into a memory word for RMW writes.
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] bit_mask;
    logic [31:0] data_rep;

    assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    assign bit_mask = expand_mask(lane_mask(lane_i, size_i));

    // Store data is replicated into every lane so the mask alone picks the target.
    always_comb begin
        case (size_i)
            SIZE_BYTE: begin
                extract_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
                data_rep  = {4{data_i[7:0]}};
            end
            SIZE_HALF: begin
                extract_o = {{16{signed_i & half_sel[15]}}, half_sel};
                data_rep  = {2{data_i[15:0]}};
            end
            default: begin
                extract_o = word_i;
                data_rep  = data_i;
            end
        endcase
    end

    assign merge_o = (word_i & ~bit_mask) | (data_rep & bit_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-wide DataMemory: fault decode, sub-word
// load extraction and a one-cycle read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_MSB  = ADDR_MSB_DEFAULT,
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input logic              clk,
    input logic              reset_n,
    mem_access_unit_if.slave bus
);

    // Address bits above ADDR_MSB must all be zero for an in-range access.
    localparam logic [31:0] HI_MASK = ~((32'h1 << (ADDR_MSB + 1)) - 32'h1);

    state_e      state_q, state_d;
    logic [31:0] cap_addr_q, cap_addr_d;
    logic [31:0] cap_data_q, cap_data_d;
    logic [1:0]  cap_lane_q, cap_lane_d;
    logic [1:0]  cap_size_q, cap_size_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        ready;
    logic        accept;
    logic        fault;
    logic        misaligned;
    logic        range_fault;
    logic [31:0] word_idx;
    logic [31:0] aligned_addr;
    logic [31:0] extract_data;
    logic [31:0] merge_data;
    logic [1:0]  lane_sel;
    logic [1:0]  size_sel;

    assign aligned_addr = {bus.req_addr[31:2], 2'b00};
    assign word_idx     = (bus.req_addr & ~HI_MASK) >> 2;
    assign range_fault  = (|(bus.req_addr & HI_MASK)) || (word_idx >= 32'(RAM_WORDS));
    assign misaligned   = ((bus.req_size == SIZE_HALF) && bus.req_addr[0]) ||
                          ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign fault        = misaligned || range_fault || (bus.req_size == SIZE_RSVD);

    assign ready  = reset_n && (state_q == IDLE);
    assign accept = bus.req_valid && ready;

    // One lane unit serves both paths: the live request in IDLE, the capture in RMW.
    assign lane_sel = (state_q == RMW) ? cap_lane_q : bus.req_addr[1:0];
    assign size_sel = (state_q == RMW) ? cap_size_q : bus.req_size;

    byte_lane_merge u_lane (
        .word_i    (bus.mem_rdata),
        .data_i    (cap_data_q),
        .lane_i    (lane_sel),
        .size_i    (size_sel),
        .signed_i  (bus.req_signed),
        .extract_o (extract_data),
        .merge_o   (merge_data)
    );

    assign bus.req_ready = ready;
    assign bus.mem_addr  = (state_q == RMW) ? cap_addr_q : aligned_addr;
    assign bus.mem_wdata = (state_q == RMW) ? merge_data : bus.req_wdata;
    assign bus.mem_we    = (state_q == RMW) ||
                           (accept && bus.req_write && (bus.req_size == SIZE_WORD) && !fault);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        // NOTE: every target gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        cap_lane_d  = cap_lane_q;
        cap_size_d  = cap_size_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (!bus.req_write) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = extract_data;
                    end else if (bus.req_size != SIZE_WORD) begin
                        cap_addr_d = aligned_addr;
                        cap_data_d = bus.req_wdata;
                        cap_lane_d = bus.req_addr[1:0];
                        cap_size_d = bus.req_size;
                        state_d    = RMW;
                    end
                end
            end
            RMW:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            cap_lane_q  <= '0;
            cap_size_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            cap_lane_q  <= cap_lane_d;
            cap_size_q  <= cap_size_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
